mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (registered 64-bit read at posedge; write at negedge; read-data mux driven live by address[2:0] and wdt_op) between the instruction-fetch unit and the load/store unit.
- Provides a valid/ready request/response handshake to each requester.
- Sequences every access and holds address and width stable for as long as the memory's output mux needs them.
- Sits between IFU/LSU and the memory module.

Parameters:
- ADDR_W, 64, address width (RegWidth).
- DATA_W, 64, data width (RegWidth/ImmWidth).
- WDT_W, 4, width-op code width; must equal `WdtTypeCnt.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid
- ifu_resp_data  out  DATA_W  fetched word, zero-extended
- ifu_resp_ready  in  1  IFU takes response
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  LSU request accepted
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_addr  in  ADDR_W  access address
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_wdt  in  WDT_W  access width code (`Wdt8/16/32/64`)
- lsu_resp_valid  out  1  load data or store ack valid
- lsu_resp_data  out  DATA_W  load data; 0 for store
- lsu_resp_ready  in  1  LSU takes response
- mem_raddr  out  ADDR_W  memory read address
- mem_waddr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data
- mem_ren  out  1  read enable
- mem_wen  out  1  write enable
- wdt_op  out  WDT_W  memory width code
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, ISSUE, DATA, RESP.
- IDLE:
  - Grant logic picks at most one requester.
  - Only the granted requester sees req_ready=1; ready is 0 in every other state.
  - On valid&ready, register owner id, addr, wen, wdata and wdt. IFU requests use wdt=`Wdt32` and wen=0.
  - Next state is ISSUE.
- ISSUE:
  - mem_raddr and mem_waddr = registered addr; wdt_op = registered wdt.
  - Load: mem_ren=1, next state DATA.
  - Store: mem_wen=1 and mem_wdata = registered wdata; the memory writes on this cycle's negedge. Next state RESP, with resp_data=0.
- DATA:
  - mem_ren=0; mem_raddr and wdt_op held at the registered values.
  - Capture mem_rdata into the response register; next state RESP.
- RESP:
  - Owner's resp_valid=1, resp_data held stable.
  - On resp_ready=1, go to IDLE. No new request is accepted in the same cycle.
- Latency, accept at cycle T:
  - Load: resp_valid from T+3.
  - Store: resp_valid from T+2.
  - Minimum back-to-back spacing: 4 cycles per load, 3 per store.
- Grant policy (default): LSU has fixed priority over IFU when both are valid in IDLE.
- Non-owner resp_valid is always 0. Both resp_valid are never 1 simultaneously.
- Outputs outside ISSUE: mem_ren=0 and mem_wen=0. Address, wdata and wdt_op keep their registered values.
- Reset values:
  - state=IDLE; all registered fields 0.
  - All outputs 0: req_ready, resp_valid, resp_data, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, wdt_op.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge.
  - mem_wen and mem_ren are gated by !rst, so no write occurs in a reset cycle, even in ISSUE.
  - In-flight requests are dropped without a response.
- Requester drops valid before ready: no effect, no state change.
- Misaligned addresses are passed through unchanged; alignment reporting belongs to memory.
- Requests arriving while busy wait. valid must be held until ready (requester rule); the bench checks it.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin grant. A last_grant bit updates on each accept; reset value = IFU.
  - On conflict in IDLE, grant the requester not granted last. The first conflict after reset goes to LSU.
  - A lone requester is always granted.
- Undefined: fixed LSU priority, no last_grant register.

Decomposition:
- Package mem_arb_pkg:
  - State enum {IDLE, ISSUE, DATA, RESP}.
  - Owner enum {OWN_IFU, OWN_LSU}.
  - Constant IFU_WDT = `Wdt32`.
- Sub-module mem_arb_grant:
  - Inputs: both valids and an idle qualifier.
  - Outputs: one-hot grant.
  - Contains the last_grant register under MEM_ARB_RR_EN.

Test Plan:
- IFU-only load of 0x8000_0010 with mem word 0x1234_5678_9ABC_DEF0:
  - mem_ren=1 at T+1.
  - mem_raddr held through T+2.
  - ifu_resp_valid=1 at T+3 with data 0x9ABC_DEF0.
- LSU store Wdt16, addr 0x8000_0102, wdata 0xBEEF:
  - mem_wen=1 exactly one cycle (T+1) with wdt_op=`Wdt16`.
  - lsu_resp_valid at T+2, data 0.
  - A later LSU Wdt16 load of 0x8000_0102 returns 0xBEEF.
- Simultaneous IFU and LSU valid in IDLE:
  - Default: LSU granted, IFU stalls ≥4 cycles, then served.
  - With MEM_ARB_RR_EN: alternating grants LSU, IFU, LSU across three conflicts.
- Response backpressure: resp_ready low for 5 cycles in RESP:
  - resp_data stable; both req_ready stay 0; no mem_ren/mem_wen pulses.
- rst=1 during ISSUE of a store:
  - mem_wen=0 in that cycle; memory word unchanged.
  - Next cycle all outputs 0 and state IDLE; no response issued.
- Back-to-back LSU loads with valid held high:
  - Second accept exactly one cycle after the first RESP handshake.
  - Each response carries its own address's data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    localparam int WDT_TYPE_CNT = 4;

    localparam logic [WDT_TYPE_CNT-1:0] WDT_8  = 4'b0001;
    localparam logic [WDT_TYPE_CNT-1:0] WDT_16 = 4'b0010;
    localparam logic [WDT_TYPE_CNT-1:0] WDT_32 = 4'b0100;
    localparam logic [WDT_TYPE_CNT-1:0] WDT_64 = 4'b1000;

    localparam logic [WDT_TYPE_CNT-1:0] IFU_WDT = WDT_32;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between IFU and LSU; bit 1 = LSU, bit 0 = IFU.
// MEM_ARB_RR_EN selects round-robin, otherwise LSU has fixed priority.
import mem_arb_pkg::*;

module mem_arb_grant (
`ifdef MEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic       idle,
    output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;

    // On conflict, favour whoever was not served last.
    always_comb begin
        grant = 2'b00;
        if (idle) begin
            if (lsu_valid && (!ifu_valid || last_grant == OWN_IFU))
                grant[1] = 1'b1;
            else if (ifu_valid)
                grant[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= OWN_IFU;
        else if (grant[1])
            last_grant <= OWN_LSU;
        else if (grant[0])
            last_grant <= OWN_IFU;
    end
`else
    always_comb begin
        grant    = 2'b00;
        grant[1] = idle && lsu_valid;
        grant[0] = idle && ifu_valid && !lsu_valid;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between IFU and LSU with valid/ready handshakes.
// Optional MEM_ARB_RR_EN: round-robin grant instead of fixed LSU priority.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int WDT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_data,
    input  logic              ifu_resp_ready,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_wen,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [WDT_W-1:0]  lsu_req_wdt,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,
    input  logic              lsu_resp_ready,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [WDT_W-1:0]  wdt_op,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WDT_W-1:0]  wdt_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        grant;
    logic              idle;
    logic              resp_ifu;
    logic              resp_lsu;
    logic              resp_take;

    assign idle = (state == IDLE) && !rst;

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .idle      (idle),
        .grant     (grant)
    );

    assign ifu_req_ready = grant[0];
    assign lsu_req_ready = grant[1];

    assign resp_ifu  = !rst && (state == RESP) && (owner == OWN_IFU);
    assign resp_lsu  = !rst && (state == RESP) && (owner == OWN_LSU);
    assign resp_take = (resp_ifu && ifu_resp_ready) ||
                       (resp_lsu && lsu_resp_ready);

    assign ifu_resp_valid = resp_ifu;
    assign lsu_resp_valid = resp_lsu;
    assign ifu_resp_data  = resp_ifu ? rdata_q : '0;
    assign lsu_resp_data  = resp_lsu ? rdata_q : '0;

    // Address/width stay on the port so the memory's live read mux is stable.
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign wdt_op    = wdt_q;
    assign mem_ren   = !rst && (state == ISSUE) && !wen_q;
    assign mem_wen   = !rst && (state == ISSUE) && wen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wdt_q   <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant[1] && lsu_req_valid) begin
                        owner   <= OWN_LSU;
                        addr_q  <= lsu_req_addr;
                        wen_q   <= lsu_req_wen;
                        wdata_q <= lsu_req_wdata;
                        wdt_q   <= lsu_req_wdt;
                        state   <= ISSUE;
                    end else if (grant[0] && ifu_req_valid) begin
                        owner   <= OWN_IFU;
                        addr_q  <= ifu_req_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wdt_q   <= WDT_W'(IFU_WDT);
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wen_q) begin
                        rdata_q <= '0;
                        state   <= RESP;
                    end else begin
                        state   <= DATA;
                    end
                end
                DATA: begin
                    rdata_q <= mem_rdata;
                    state   <= RESP;
                end
                RESP: begin
                    if (resp_take)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural data memory.
// Grant-order expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam logic [63:0] A  = 64'h8000_0010;
    localparam logic [63:0] B  = 64'h8000_0102;
    localparam logic [63:0] RA = 64'h8000_0140;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [63:0] ifu_req_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic        lsu_resp_valid, lsu_resp_ready;
    logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [3:0]  lsu_req_wdt, wdt_op;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_data(ifu_resp_data), .ifu_resp_ready(ifu_resp_ready),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wdt(lsu_req_wdt),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .lsu_resp_ready(lsu_resp_ready),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .wdt_op(wdt_op),
        .mem_rdata(mem_rdata)
    );

    // Memory model: registered word read at posedge, write at negedge, live mux.
    logic [63:0] mem [0:63];
    logic [63:0] rword = 64'h0;

    function automatic logic [63:0] wmask(logic [3:0] w);
        case (w)
            WDT_8:   return 64'hFF;
            WDT_16:  return 64'hFFFF;
            WDT_32:  return 64'hFFFF_FFFF;
            default: return '1;
        endcase
    endfunction

    assign mem_rdata = (rword >> {mem_raddr[2:0], 3'b000}) & wmask(wdt_op);

    always @(posedge clk)
        if (mem_ren) rword <= mem[mem_raddr[8:3]];

    initial begin
        logic [63:0] m;
        for (int i = 0; i < 64; i++) mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
        mem[2]  = 64'h1234_5678_9ABC_DEF0;
        mem[32] = 64'h1111_2222_3333_4444;
        mem[40] = 64'hAAAA_BBBB_CCCC_DDDD;
        forever begin
            @(negedge clk);
            if (mem_wen) begin
                m = wmask(wdt_op) << {mem_waddr[2:0], 3'b000};
                mem[mem_waddr[8:3]] = (mem[mem_waddr[8:3]] & ~m) |
                    ((mem_wdata << {mem_waddr[2:0], 3'b000}) & m);
            end
        end
    end

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    typedef struct {
        logic        rst, iv;
        logic [63:0] ia;
        logic        lv, lw;
        logic [63:0] la, ld;
        logic [3:0]  lt;
        logic        irr, lrr;
        logic [5:0]  e_flags;
        logic [3:0]  e_wdt;
        logic [63:0] e_raddr, e_idata, e_ldata;
    } vec_t;

    function automatic vec_t v(
        logic r, logic iv, logic [63:0] ia, logic lv, logic lw,
        logic [63:0] la, logic [63:0] ld, logic [3:0] lt,
        logic irr, logic lrr, logic [5:0] ef, logic [3:0] ew,
        logic [63:0] er, logic [63:0] ei, logic [63:0] el);
        vec_t t;
        t.rst = r; t.iv = iv; t.ia = ia; t.lv = lv; t.lw = lw;
        t.la = la; t.ld = ld; t.lt = lt; t.irr = irr; t.lrr = lrr;
        t.e_flags = ef; t.e_wdt = ew; t.e_raddr = er;
        t.e_idata = ei; t.e_ldata = el;
        return t;
    endfunction

    function automatic logic [201:0] outs();
        return {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                mem_ren, mem_wen, wdt_op, mem_raddr, ifu_resp_data,
                lsu_resp_data};
    endfunction

    vec_t vecs [17];
    int   exp_order [3];
    int   order [3];
    int   acc_c [3];
    int   n, cc, first_ifu;
    logic found;

    initial begin
        // flags: {ifu_ready, lsu_ready, ifu_rv, lsu_rv, ren, wen}
        vecs[0]  = v(1,0,0,0,0,0,0,0,0,0, 6'b000000, 4'h0, 0, 0, 0);
        vecs[1]  = v(0,0,0,0,0,0,0,0,0,0, 6'b000000, 4'h0, 0, 0, 0);
        vecs[2]  = v(0,1,A,0,0,0,0,0,0,0, 6'b100000, 4'h0, 0, 0, 0);
        vecs[3]  = v(0,0,0,0,0,0,0,0,0,0, 6'b000010, WDT_32, A, 0, 0);
        vecs[4]  = v(0,0,0,0,0,0,0,0,0,0, 6'b000000, WDT_32, A, 0, 0);
        vecs[5]  = v(0,0,0,0,0,0,0,0,0,0, 6'b001000, WDT_32, A, 64'h9ABC_DEF0, 0);
        vecs[6]  = v(0,0,0,0,0,0,0,0,1,0, 6'b001000, WDT_32, A, 64'h9ABC_DEF0, 0);
        vecs[7]  = v(0,0,0,0,0,0,0,0,0,0, 6'b000000, WDT_32, A, 0, 0);
        vecs[8]  = v(0,0,0,1,1,B,64'hBEEF,WDT_16,0,0, 6'b010000, WDT_32, A, 0, 0);
        vecs[9]  = v(0,0,0,0,0,0,0,0,0,0, 6'b000001, WDT_16, B, 0, 0);
        vecs[10] = v(0,0,0,0,0,0,0,0,0,1, 6'b000100, WDT_16, B, 0, 0);
        vecs[11] = v(0,0,0,0,0,0,0,0,0,0, 6'b000000, WDT_16, B, 0, 0);
        vecs[12] = v(0,0,0,1,0,B,0,WDT_16,0,0, 6'b010000, WDT_16, B, 0, 0);
        vecs[13] = v(0,0,0,0,0,0,0,0,0,0, 6'b000010, WDT_16, B, 0, 0);
        vecs[14] = v(0,0,0,0,0,0,0,0,0,0, 6'b000000, WDT_16, B, 0, 0);
        vecs[15] = v(0,0,0,0,0,0,0,0,0,1, 6'b000100, WDT_16, B, 0, 64'hBEEF);
        vecs[16] = v(0,0,0,0,0,0,0,0,0,0, 6'b000000, WDT_16, B, 0, 0);

`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 0, 1};
`else
        exp_order = '{1, 1, 1};
`endif

        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0;
        lsu_req_wdata = 0; lsu_req_wdt = 0; lsu_resp_ready = 0;
        tick();

        for (int i = 0; i < 17; i++) begin
            rst = vecs[i].rst;
            ifu_req_valid = vecs[i].iv; ifu_req_addr = vecs[i].ia;
            lsu_req_valid = vecs[i].lv; lsu_req_wen = vecs[i].lw;
            lsu_req_addr = vecs[i].la; lsu_req_wdata = vecs[i].ld;
            lsu_req_wdt = vecs[i].lt;
            ifu_resp_ready = vecs[i].irr; lsu_resp_ready = vecs[i].lrr;
            settle();
            chk($sformatf("vec%0d", i), 256'(outs()),
                256'({vecs[i].e_flags, vecs[i].e_wdt, vecs[i].e_raddr,
                      vecs[i].e_idata, vecs[i].e_ldata}));
            tick();
        end

        // Conflict: both requesters held valid across three accepts.
        ifu_req_valid = 1; ifu_req_addr = A; ifu_resp_ready = 1;
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = B;
        lsu_req_wdt = WDT_16; lsu_resp_ready = 1;
        n = 0; cc = 0; first_ifu = -1;
        for (int c = 0; c < 40 && n < 3; c++) begin
            settle();
            if (ifu_req_ready || lsu_req_ready) begin
                chk("grant_onehot", 256'(ifu_req_ready && lsu_req_ready), 0);
                order[n] = lsu_req_ready ? 1 : 0;
                acc_c[n] = cc;
                if (ifu_req_ready && first_ifu < 0) first_ifu = cc;
                n++;
            end
            tick();
            cc++;
        end
        chk("conflict_accepts", 256'(n), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("grant_order%0d", k), 256'(order[k]), 256'(exp_order[k]));
        chk("gap01", 256'(acc_c[1] - acc_c[0]), 4);
        chk("gap12", 256'(acc_c[2] - acc_c[1]), 4);
        lsu_req_valid = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            settle();
            if (ifu_req_ready) begin
                found = 1;
                if (first_ifu < 0) first_ifu = cc;
            end
            tick();
            cc++;
        end
        chk("ifu_served", 256'(found), 1);
`ifdef MEM_ARB_RR_EN
        chk("ifu_first_cycle", 256'(first_ifu), 4);
`else
        chk("ifu_first_cycle", 256'(first_ifu), 12);
`endif
        ifu_req_valid = 0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            settle();
            if (ifu_resp_valid) found = 1;
            else tick();
        end
        chk("ifu_conflict_data", 256'({found, ifu_resp_data}),
            256'({1'b1, 64'h9ABC_DEF0}));
        tick();

        // Backpressure on an LSU doubleword load.
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = A;
        lsu_req_wdt = WDT_64; lsu_resp_ready = 0;
        settle();
        chk("bp_accept", 256'(lsu_req_ready), 1);
        tick();
        ifu_req_valid = 1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            settle();
            if (lsu_resp_valid) found = 1;
            else tick();
        end
        chk("bp_resp_seen", 256'(found), 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                tick();
                settle();
            end
            chk($sformatf("bp_hold%0d", k),
                256'({lsu_resp_valid, lsu_resp_data, ifu_req_ready,
                      lsu_req_ready, mem_ren, mem_wen}),
                256'({1'b1, 64'h1234_5678_9ABC_DEF0, 4'b0000}));
        end
        tick();
        lsu_resp_ready = 1; ifu_req_valid = 0; lsu_req_valid = 0;
        settle();
        chk("bp_handshake",
            256'({lsu_resp_valid, ifu_req_ready, lsu_req_ready}), 256'(3'b100));
        tick();
        settle();
        chk("bp_idle", 256'({lsu_resp_valid, ifu_resp_valid, mem_ren}), 0);

        // Back-to-back LSU loads with valid held high.
        tick();
        lsu_req_valid = 1; lsu_req_addr = A; lsu_req_wdt = WDT_32;
        lsu_resp_ready = 1;
        settle();
        chk("b2b_acc1", 256'(lsu_req_ready), 1);
        tick();
        lsu_req_addr = B; lsu_req_wdt = WDT_16;
        settle();
        tick();
        settle();
        tick();
        settle();
        chk("b2b_resp1", 256'({lsu_resp_valid, lsu_resp_data}),
            256'({1'b1, 64'h9ABC_DEF0}));
        tick();
        settle();
        chk("b2b_acc2", 256'(lsu_req_ready), 1);
        tick();
        lsu_req_valid = 0;
        settle();
        tick();
        settle();
        tick();
        settle();
        chk("b2b_resp2", 256'({lsu_resp_valid, lsu_resp_data}),
            256'({1'b1, 64'hBEEF}));
        tick();

        // Reset asserted during the ISSUE cycle of a store.
        lsu_resp_ready = 0;
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = RA;
        lsu_req_wdata = 64'h5555; lsu_req_wdt = WDT_64;
        settle();
        chk("rst_st_accept", 256'(lsu_req_ready), 1);
        tick();
        lsu_req_valid = 0; lsu_req_wen = 0; rst = 1;
        settle();
        chk("rst_no_wen", 256'({mem_wen, mem_ren}), 0);
        tick();
        rst = 0;
        settle();
        chk("rst_all_zero",
            256'({outs(), mem_waddr[15:0], mem_wdata[15:0]}), 0);
        found = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            if (lsu_resp_valid || ifu_resp_valid || mem_wen) found = 1;
        end
        chk("rst_no_resp", 256'(found), 0);
        chk("rst_mem_kept", 256'(mem[40]), 256'(64'hAAAA_BBBB_CCCC_DDDD));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
